// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: one outstanding request, single-entry instruction holding
// register, branch redirect with stale-response draining. Optional macro PC_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        trap
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_WAIT  = 3'd1,
        S_OUT   = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_req_valid;
    logic        r_instr_valid;
    logic        r_trap;

    logic        w_redirect;
    logic        w_misaligned;
    logic [31:0] w_target;

    assign w_redirect = br_valid & br_taken;

`ifdef PC_MISALIGN_TRAP_EN
    assign w_misaligned = |br_target[1:0];
    assign w_target     = br_target;
`else
    assign w_misaligned = 1'b0;
    assign w_target     = br_target & 32'hFFFF_FFFC;
`endif

    assign imem_req_valid = r_req_valid;
    assign imem_addr      = r_pc;
    assign instr_valid    = r_instr_valid;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign trap           = r_trap;

    // Fetch FSM; every output is a flop updated together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0000_0000;
            r_instr_pc    <= 32'h0000_0000;
            r_req_valid   <= 1'b1;
            r_instr_valid <= 1'b0;
            r_trap        <= 1'b0;
        end else if ((r_state != S_HALT) && w_redirect && w_misaligned) begin
            // HALT drives every output low except trap, so the data path is cleared too.
            r_state       <= S_HALT;
            r_pc          <= 32'h0000_0000;
            r_instr       <= 32'h0000_0000;
            r_instr_pc    <= 32'h0000_0000;
            r_req_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_trap        <= 1'b1;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                        if (imem_req_ready) begin
                            r_state     <= S_DRAIN;
                            r_req_valid <= 1'b0;
                        end else begin
                            r_state     <= S_FETCH;
                            r_req_valid <= 1'b1;
                        end
                    end else if (imem_req_ready) begin
                        r_state     <= S_WAIT;
                        r_req_valid <= 1'b0;
                    end else begin
                        r_state     <= S_FETCH;
                        r_req_valid <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                        if (imem_rsp_valid) begin
                            r_state     <= S_FETCH;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_state     <= S_DRAIN;
                            r_req_valid <= 1'b0;
                        end
                    end else if (imem_rsp_valid) begin
                        r_instr       <= imem_rsp_data;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_OUT;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_OUT: begin
                    if (w_redirect) begin
                        r_pc          <= w_target;
                        r_instr_valid <= 1'b0;
                        r_req_valid   <= 1'b1;
                        r_state       <= S_FETCH;
                    end else if (instr_ready) begin
                        r_pc          <= r_pc + 32'd4;
                        r_instr_valid <= 1'b0;
                        r_req_valid   <= 1'b1;
                        r_state       <= S_FETCH;
                    end else begin
                        r_state <= S_OUT;
                    end
                end
                S_DRAIN: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end else begin
                        r_pc <= r_pc;
                    end
                    // A response arriving with a redirect still retires the stale request.
                    if (imem_rsp_valid) begin
                        r_state     <= S_FETCH;
                        r_req_valid <= 1'b1;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state       <= S_FETCH;
                    r_req_valid   <= 1'b1;
                    r_instr_valid <= 1'b0;
                    r_trap        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pc_fetch_unit;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        instr_valid, instr_ready, br_valid, br_taken, trap;
    logic [31:0] imem_addr, imem_rsp_data, instr, instr_pc, br_target;

    logic        rst2, req_valid2, req_ready2, rsp_valid2, ivalid2, iready2, trap2;
    logic [31:0] addr2, rsp_data2, instr2, ipc2;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target), .trap(trap)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2),
        .imem_req_valid(req_valid2), .imem_req_ready(req_ready2), .imem_addr(addr2),
        .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
        .instr_valid(ivalid2), .instr_ready(iready2), .instr(instr2), .instr_pc(ipc2),
        .br_valid(1'b0), .br_taken(1'b0), .br_target(32'h0000_0000), .trap(trap2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction model: pc, whether a request is in flight (and whether it is stale),
    // whether an instruction is held for decode, and the halted flag.
    logic [31:0] m_pc, m_word, m_wpc;
    bit          m_out, m_stale, m_held, m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_step();
        bit          redir;
        logic [31:0] tgt;
        redir = br_valid && br_taken;
        tgt   = TRAP_EN ? br_target : (br_target - (br_target % 32'd4));
        if (rst) begin
            m_pc = 32'h0; m_word = 32'h0; m_wpc = 32'h0;
            m_out = 0; m_stale = 0; m_held = 0; m_halt = 0;
        end else if (m_halt) begin
            m_halt = 1;
        end else if (redir && TRAP_EN && (br_target % 32'd4) != 32'd0) begin
            m_halt = 1; m_out = 0; m_stale = 0; m_held = 0;
            m_pc = 32'h0; m_word = 32'h0; m_wpc = 32'h0;
        end else if (m_out && m_stale) begin
            if (redir) m_pc = tgt;
            if (imem_rsp_valid) begin m_out = 0; m_stale = 0; end
        end else if (m_out) begin
            if (redir) begin
                m_pc = tgt;
                if (imem_rsp_valid) m_out = 0;
                else m_stale = 1;
            end else if (imem_rsp_valid) begin
                m_held = 1; m_word = imem_rsp_data; m_wpc = m_pc; m_out = 0;
            end
        end else if (m_held) begin
            if (redir) begin m_held = 0; m_pc = tgt; end
            else if (instr_ready) begin m_held = 0; m_pc = m_pc + 32'd4; end
        end else begin
            if (redir) begin
                m_pc = tgt;
                if (imem_req_ready) begin m_out = 1; m_stale = 1; end
            end else if (imem_req_ready) begin
                m_out = 1; m_stale = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("req_valid", 32'(imem_req_valid), 32'(!m_halt && !m_out && !m_held));
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_held));
        chk("trap", 32'(trap), 32'(m_halt));
        if (m_held || m_halt) begin
            chk("instr", instr, m_word);
            chk("instr_pc", instr_pc, m_wpc);
        end
    endtask

    task automatic quiet();
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 32'h0;
        instr_ready = 0; br_valid = 0; br_taken = 0; br_target = 32'h0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    logic [31:0] q_req[$];
    logic [31:0] q_ipc[$];
    bit          found;
    bit          seen_stale;

    initial begin
        rst2 = 1; req_ready2 = 0; rsp_valid2 = 0; rsp_data2 = 32'h0; iready2 = 0;
        quiet();
        m_halt = 0; m_out = 0; m_stale = 0; m_held = 0;
        m_pc = 32'h0; m_word = 32'h0; m_wpc = 32'h0;
        do_reset();
        chk("reset_addr", imem_addr, 32'h0000_0000);
        chk("reset_req_valid", 32'(imem_req_valid), 32'd1);
        chk("reset_instr_valid", 32'(instr_valid), 32'd0);
        chk("reset_trap", 32'(trap), 32'd0);

        // Sequential fetch with an always-ready memory and decoder.
        imem_req_ready = 1; imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0013; instr_ready = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (instr_valid && instr_pc == 32'h10) found = 1;
            else begin
                if (imem_req_valid && imem_req_ready) q_req.push_back(imem_addr);
                if (instr_valid && instr_ready) q_ipc.push_back(instr_pc);
                cycle();
            end
        end
        chk("reach_pc_0x10", 32'(found), 32'd1);
        chk("n_req", 32'(q_req.size() >= 3), 32'd1);
        chk("n_ipc", 32'(q_ipc.size() >= 3), 32'd1);
        if (q_req.size() >= 3 && q_ipc.size() >= 3) begin
            chk("seq_req0", q_req[0], 32'h0); chk("seq_req1", q_req[1], 32'h4);
            chk("seq_req2", q_req[2], 32'h8);
            chk("seq_ipc0", q_ipc[0], 32'h0); chk("seq_ipc1", q_ipc[1], 32'h4);
            chk("seq_ipc2", q_ipc[2], 32'h8);
        end
        chk("seq_instr", instr, 32'h0000_0013);

        // Redirect in OUT wins over a simultaneous consume.
        br_valid = 1; br_taken = 1; br_target = 32'h100;
        cycle();
        chk("redir_out_drop", 32'(instr_valid), 32'd0);
        chk("redir_out_addr", imem_addr, 32'h100);
        chk("redir_out_req", 32'(imem_req_valid), 32'd1);

        // Redirect in WAIT, stale response three cycles later.
        br_valid = 0; imem_rsp_valid = 0; instr_ready = 0; imem_req_ready = 1;
        cycle();
        chk("wait_no_req", 32'(imem_req_valid), 32'd0);
        imem_req_ready = 0; br_valid = 1; br_target = 32'h40;
        cycle();
        br_valid = 0;
        seen_stale = 0;
        cycle();
        cycle();
        chk("drain_no_req", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
        cycle();
        if (instr_valid && instr == 32'hDEAD_BEEF) seen_stale = 1;
        chk("after_drain_addr", imem_addr, 32'h40);
        chk("after_drain_req", 32'(imem_req_valid), 32'd1);
        imem_rsp_valid = 0; imem_req_ready = 1;
        cycle();
        imem_rsp_valid = 1; imem_rsp_data = 32'h0050_0093;
        cycle();
        if (instr_valid && instr == 32'hDEAD_BEEF) seen_stale = 1;
        chk("stale_never_seen", 32'(seen_stale), 32'd0);
        chk("fresh_instr", instr, 32'h0050_0093);
        chk("fresh_instr_pc", instr_pc, 32'h40);

        // Decoder back-pressure: holding register frozen, no new requests.
        for (int i = 0; i < 5; i++) begin
            imem_rsp_data = $urandom;
            cycle();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", instr, 32'h0050_0093);
            chk("stall_pc", instr_pc, 32'h40);
            chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        end

        // Misaligned redirect target.
        imem_rsp_valid = 0; br_valid = 1; br_taken = 1; br_target = 32'h102;
        cycle();
        br_valid = 0;
        if (TRAP_EN) begin
            for (int i = 0; i < 4; i++) begin
                chk("halt_trap", 32'(trap), 32'd1);
                chk("halt_no_req", 32'(imem_req_valid), 32'd0);
                chk("halt_no_instr", 32'(instr_valid), 32'd0);
                cycle();
            end
        end else begin
            chk("misalign_addr", imem_addr, 32'h100);
            chk("misalign_req", 32'(imem_req_valid), 32'd1);
            chk("misalign_trap", 32'(trap), 32'd0);
        end

        // Randomized traffic, including spurious responses, resets and wrap-prone targets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            imem_req_ready = ($urandom_range(0, 1) == 1);
            imem_rsp_valid = ($urandom_range(0, 2) == 0);
            imem_rsp_data  = $urandom;
            instr_ready    = ($urandom_range(0, 1) == 1);
            br_valid       = ($urandom_range(0, 7) == 0);
            br_taken       = ($urandom_range(0, 1) == 1);
            br_target      = $urandom;
            if ($urandom_range(0, 3) == 0) br_target = 32'hFFFF_FFF0 | (br_target & 32'hF);
            if (TRAP_EN && $urandom_range(0, 9) != 0) br_target = br_target & 32'hFFFF_FFFC;
            cycle();
        end
        rst = 0;
        quiet();

        // Reset PC at the top of the address space wraps to zero.
        rst2 = 1;
        @(posedge clk); #1;
        rst2 = 0;
        chk("wrap_reset_addr", addr2, 32'hFFFF_FFFC);
        chk("wrap_reset_req", 32'(req_valid2), 32'd1);
        req_ready2 = 1; rsp_valid2 = 1; rsp_data2 = 32'h0000_0013; iready2 = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wrap_instr_valid", 32'(ivalid2), 32'd1);
        chk("wrap_instr_pc", ipc2, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("wrap_next_addr", addr2, 32'h0000_0000);
        chk("wrap_next_req", 32'(req_valid2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
